stat_pkt: RTL and testbench
===========================

STAT_PKT -- requirements
Module: stat_pkt

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, width of each per-flow byte counter and of rd_data_o.
REQ-002 SHALL have parameter A_WIDTH, default 3, flow-number width; the module holds 2**A_WIDTH flows.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_flow_num_i  input  A_WIDTH  flow number of the received packet.
REQ-006 SHALL have port pkt_size_i  input  16  packet size in bytes.
REQ-007 SHALL have port pkt_size_ena_i  input  1  qualifies rx_flow_num_i/pkt_size_i for one cycle.
REQ-008 SHALL have port rd_stb_i  input  1  one-cycle read request.
REQ-009 SHALL have port rd_flow_num_i  input  A_WIDTH  flow to read, sampled with rd_stb_i.
REQ-010 SHALL have port rd_data_o  output  D_WIDTH  counter value returned for a read.
REQ-011 SHALL have port rd_data_val_o  output  1  one-cycle pulse qualifying rd_data_o.

Function
REQ-012 Each cycle with pkt_size_ena_i=1, the counter of rx_flow_num_i SHALL increase by pkt_size_i, zero-extended to D_WIDTH.
REQ-013 Addition SHALL saturate at all-ones (2**D_WIDTH-1); no wrap-around.
REQ-014 Updates SHALL be accepted every cycle without back-pressure; back-to-back updates to the same flow SHALL all be counted (internal forwarding of pending read-modify-write results).
REQ-015 rd_stb_i=1 SHALL cause rd_data_val_o=1 exactly 2 cycles later for exactly one cycle, rd_data_o holding the counter of rd_flow_num_i.
REQ-016 Reads SHALL be accepted every cycle, fully pipelined; each strobe yields one response in order.
REQ-017 The read value SHALL include every update sampled in cycles before the read strobe and exclude the update sampled in the same cycle.
REQ-018 rd_data_o SHALL hold its last value while rd_data_val_o=0.
REQ-019 Update and read of different flows in the same cycle SHALL proceed independently.

Reset
REQ-020 While rst_i=0 all counters, rd_data_o and rd_data_val_o SHALL be 0 asynchronously; pending reads SHALL be discarded.
REQ-021 The first update or read SHALL be accepted on the first rising clk_i edge after rst_i rises.
REQ-022 Reset asserted mid-operation SHALL abort in-flight updates and reads with no rd_data_val_o pulse.

Configuration
REQ-023 With macro STAT_PKT_CLEAR_ON_READ_EN defined, a read SHALL clear the read flow's counter; an update of that flow in the read-strobe cycle SHALL then leave the counter equal to that packet's size.
REQ-024 Without STAT_PKT_CLEAR_ON_READ_EN, reads SHALL be non-destructive and counters change only by updates and reset.

Structure
REQ-025 Package stat_pkt_pkg SHALL hold default D_WIDTH/A_WIDTH constants, PKT_SIZE_W=16 and the counter typedef.
REQ-026 Counter storage SHALL be sub-module stat_pkt_mem: 2**A_WIDTH x D_WIDTH register array, async clear, one write port, two read ports (update and host read).

Verification
REQ-027 Flow 0: nine consecutive cycles of pkt_size_i=100 with ena 1,1,1,1,1,1,0,1,0, then read flow 0 -> rd_data_o=700, rd_data_val_o 2 cycles after strobe.
REQ-028 Updates flow 3 size 5 every cycle for 10 cycles, read flow 3 -> 50; read flow 2 -> 0.
REQ-029 Flow 1 preloaded near all-ones, add 16'hFFFF -> read returns 2**D_WIDTH-1.
REQ-030 Read flow 4 in same cycle as update flow 4 size 10 (prior sum 20) -> returns 20; with STAT_PKT_CLEAR_ON_READ_EN next read returns 10, without it 30.
REQ-031 Read strobes on 3 consecutive cycles to flows 0,1,2 -> 3 consecutive valid pulses, correct values in order.
REQ-032 Assert rst_i=0 one cycle after a read strobe -> no rd_data_val_o pulse; all flows read 0 afterwards.

Source files
------------

// File: rtl/stat_pkt_pkg.sv
// Shared constants and types for the per-flow packet byte statistics block.
package stat_pkt_pkg;
    localparam int D_WIDTH_DEF = 32;
    localparam int A_WIDTH_DEF = 3;
    localparam int PKT_SIZE_W  = 16;

    typedef logic [D_WIDTH_DEF-1:0] cnt_t;
endpackage

// File: rtl/stat_pkt_mem.sv
// Counter storage: flat register array, async clear, one write port,
// two combinational read ports (update path and host read path).
module stat_pkt_mem
    import stat_pkt_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [A_WIDTH-1:0] wr_addr_i,
    input  logic [D_WIDTH-1:0] wr_data_i,
    input  logic [A_WIDTH-1:0] upd_addr_i,
    output logic [D_WIDTH-1:0] upd_data_o,
    input  logic [A_WIDTH-1:0] hst_addr_i,
    output logic [D_WIDTH-1:0] hst_data_o
);
    logic [2**A_WIDTH-1:0][D_WIDTH-1:0] mem;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            mem <= '0;
        else if (wr_en_i)
            mem[wr_addr_i] <= wr_data_i;
    end

    assign upd_data_o = mem[upd_addr_i];
    assign hst_data_o = mem[hst_addr_i];
endmodule

// File: rtl/stat_pkt.sv
// Per-flow saturating byte counters with a 2-cycle pipelined host read port.
// Optional macro STAT_PKT_CLEAR_ON_READ_EN makes host reads clear the counter.
module stat_pkt
    import stat_pkt_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [A_WIDTH-1:0]    rx_flow_num_i,
    input  logic [PKT_SIZE_W-1:0] pkt_size_i,
    input  logic                  pkt_size_ena_i,
    input  logic                  rd_stb_i,
    input  logic [A_WIDTH-1:0]    rd_flow_num_i,
    output logic [D_WIDTH-1:0]    rd_data_o,
    output logic                  rd_data_val_o
);
    localparam int NUM_FLOWS = 2**A_WIDTH;

    logic [D_WIDTH-1:0] upd_cur, hst_cur, upd_base, rd_val, upd_sum, sum_raw;
    logic               carry;
    logic [D_WIDTH-1:0] rd_q;
    logic [1:0]         vld_pipe;

    // The read-modify-write completes in one cycle, so a back-to-back update
    // of the same flow already sees the previous result in the array.
    stat_pkt_mem #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_mem (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (pkt_size_ena_i),
        .wr_addr_i  (rx_flow_num_i),
        .wr_data_i  (upd_sum),
        .upd_addr_i (rx_flow_num_i),
        .upd_data_o (upd_cur),
        .hst_addr_i (rd_flow_num_i),
        .hst_data_o (hst_cur)
    );

`ifdef STAT_PKT_CLEAR_ON_READ_EN
    // Clears are deferred: a stale flag makes the stored value read as zero
    // until the next update rewrites the entry, keeping a single write port.
    logic [NUM_FLOWS-1:0] stale;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stale <= '0;
        else
            for (int f = 0; f < NUM_FLOWS; f++) begin
                if (pkt_size_ena_i && rx_flow_num_i == A_WIDTH'(f))
                    stale[f] <= 1'b0;
                else if (rd_stb_i && rd_flow_num_i == A_WIDTH'(f))
                    stale[f] <= 1'b1;
            end
    end

    assign upd_base = (stale[rx_flow_num_i] || (rd_stb_i && rd_flow_num_i == rx_flow_num_i))
                      ? '0 : upd_cur;
    assign rd_val   = stale[rd_flow_num_i] ? '0 : hst_cur;
`else
    assign upd_base = upd_cur;
    assign rd_val   = hst_cur;
`endif

    assign {carry, sum_raw} = {1'b0, upd_base} + (D_WIDTH+1)'(pkt_size_i);
    assign upd_sum          = carry ? '1 : sum_raw;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_pipe  <= '0;
            rd_q      <= '0;
            rd_data_o <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], rd_stb_i};
            if (rd_stb_i)
                rd_q <= rd_val;
            if (vld_pipe[0])
                rd_data_o <= rd_q;
        end
    end

    assign rd_data_val_o = vld_pipe[1];
endmodule

// File: tb/tb_stat_pkt.sv
// Randomized + directed bench for stat_pkt against a per-flow array model.
module tb_stat_pkt;
    localparam int DW = 20;   // narrow counters so saturation is reachable quickly
    localparam int AW = 3;
    localparam int NF = 2**AW;
    localparam longint MAXV = (64'd1 << DW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [AW-1:0] rx_flow_num_i = '0;
    logic [15:0]   pkt_size_i = '0;
    logic          pkt_size_ena_i = 1'b0;
    logic          rd_stb_i = 1'b0;
    logic [AW-1:0] rd_flow_num_i = '0;
    logic [DW-1:0] rd_data_o;
    logic          rd_data_val_o;

    always #5 clk_i = ~clk_i;

    stat_pkt #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_flow_num_i  (rx_flow_num_i),
        .pkt_size_i     (pkt_size_i),
        .pkt_size_ena_i (pkt_size_ena_i),
        .rd_stb_i       (rd_stb_i),
        .rd_flow_num_i  (rd_flow_num_i),
        .rd_data_o      (rd_data_o),
        .rd_data_val_o  (rd_data_val_o)
    );

    typedef struct { int due; longint val; } rsp_t;

    int     n_chk = 0;
    int     n_pass = 0;
    int     cyc = 0;
    longint cnt [NF];
    longint last_d = 0;
    rsp_t   rq [$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock: drive inputs, advance model at the edge, check outputs just after.
    task automatic tick(input bit ena, input int fl, input int sz, input bit stb, input int rf);
        rx_flow_num_i  = AW'(fl);
        pkt_size_i     = 16'(sz);
        pkt_size_ena_i = ena;
        rd_stb_i       = stb;
        rd_flow_num_i  = AW'(rf);
        @(posedge clk_i);
        cyc++;
        if (rst_i) begin
            if (stb) begin
                rq.push_back('{cyc + 1, cnt[rf]});
`ifdef STAT_PKT_CLEAR_ON_READ_EN
                cnt[rf] = 0;
`endif
            end
            if (ena) begin
                cnt[fl] += sz;
                if (cnt[fl] > MAXV) cnt[fl] = MAXV;
            end
        end
        #1;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            last_d = rq[0].val;
            void'(rq.pop_front());
            chk("rd_valid", longint'(rd_data_val_o), 1);
            chk("rd_data", longint'(rd_data_o), last_d);
        end else begin
            chk("rd_idle", longint'(rd_data_val_o), 0);
            chk("rd_hold", longint'(rd_data_o), last_d);
        end
    endtask

    task automatic read_flow(input int rf, input longint exp, input string tag);
        tick(0, 0, 0, 1, rf);
        tick(0, 0, 0, 0, 0);
        chk(tag, longint'(rd_data_o), exp);
        chk({tag, "_val"}, longint'(rd_data_val_o), 1);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        chk("rst_val", longint'(rd_data_val_o), 0);
        chk("rst_data", longint'(rd_data_o), 0);
        foreach (cnt[i]) cnt[i] = 0;
        rq.delete();
        last_d = 0;
        repeat (2) tick(0, 0, 0, 0, 0);
        rst_i = 1'b1;
    endtask

    initial begin
        bit ens [9] = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
        do_reset();

        // seven qualified 100-byte packets on flow 0
        foreach (ens[i]) tick(ens[i], 0, 100, 0, 0);
        read_flow(0, 700, "sum_f0");

        repeat (10) tick(1, 3, 5, 0, 0);
        read_flow(3, 50, "sum_f3");
        read_flow(2, 0, "empty_f2");

        // 16 * 0xFFFF leaves flow 1 just below all-ones; one more must saturate
        repeat (16) tick(1, 1, 16'hFFFF, 0, 0);
        tick(1, 1, 16'hFFFF, 0, 0);
        read_flow(1, MAXV, "sat_f1");

        tick(1, 4, 10, 0, 0);
        tick(1, 4, 10, 0, 0);
        tick(1, 4, 10, 1, 4);
        tick(0, 0, 0, 0, 0);
        chk("same_cyc_f4", longint'(rd_data_o), 20);
`ifdef STAT_PKT_CLEAR_ON_READ_EN
        read_flow(4, 10, "after_f4");
`else
        read_flow(4, 30, "after_f4");
`endif

        // back-to-back strobes with an unrelated update stream
        tick(1, 5, 7, 1, 0);
        tick(1, 5, 7, 1, 1);
        tick(1, 5, 7, 1, 2);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        read_flow(5, 21, "indep_f5");

        // reset lands one cycle after a strobe: its response must vanish
        tick(1, 6, 9, 1, 0);
        do_reset();
        for (int f = 0; f < NF; f++) read_flow(f, 0, "post_rst");

        for (int i = 0; i < 400; i++) begin
            int sz;
            sz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 300));
            tick(bit'($urandom_range(0, 1)), int'($urandom_range(0, NF - 1)), sz,
                 bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, NF - 1)));
        end
        repeat (3) tick(0, 0, 0, 0, 0);
        chk("drain", longint'(rq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
